// File: rtl/montgomery_radix4_param_if.sv
// Request/response bundle for the radix-4 Montgomery multiplier.
// The master drives operands and start; the slave returns result, done and busy.
interface montgomery_radix4_param_if #(
    parameter int N = 1024
) ();
    logic         start;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;
    logic         busy;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, done, busy
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, done, busy
    );
endinterface

// File: rtl/montgomery_radix4_param.sv
// Radix-4 Montgomery multiplier: result = A*B*2^-N mod M, one 2-bit digit of A
// per ADDB/ADDM pair, followed by a single conditional final subtraction.
module montgomery_radix4_param #(
    parameter int N = 1024
) (
    input logic clk,
    input logic reset,
    montgomery_radix4_param_if.slave bus
);
    localparam int W  = N + 3;
    localparam int IW = $clog2(N / 2) + 1;
    localparam logic [IW-1:0] LAST_DIGIT = IW'(N / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ADDB,
        ADDM,
        SUB,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  m_reg;
    logic [N-1:0]  a_shift;
    logic [N-1:0]  result_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  b_triple;
    logic [W-1:0]  m_triple;
    logic [IW-1:0] digit_idx;

    logic [1:0]    digit;
    logic [1:0]    q_prod;
    logic [1:0]    q;
    logic [W-1:0]  b_mult;
    logic [W-1:0]  m_mult;
    logic [W-1:0]  sum_b;
    logic [W-1:0]  sum_m;
    logic [W-1:0]  m_wide;
    logic [W-1:0]  diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus.done   = 1'b0;
        bus.busy   = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    next_state = PRE;
                end
            end
            PRE:  next_state = ADDB;
            ADDB: next_state = ADDM;
            ADDM: next_state = (digit_idx == LAST_DIGIT) ? SUB : ADDB;
            SUB:  next_state = DONE;
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.result = result_reg;
    assign m_wide     = {3'b000, m_reg};
    assign digit      = a_shift[1:0];

    // Since M is odd, M^-1 mod 4 equals M[1:0], so q = -C*M[1:0] mod 4.
    always_comb begin
        q_prod = acc[1:0] * m_reg[1:0];
        q      = 2'd0 - q_prod;
    end

    always_comb begin
        b_mult = '0;
        case (digit)
            2'd0: b_mult = '0;
            2'd1: b_mult = {3'b000, b_reg};
            2'd2: b_mult = {2'b00, b_reg, 1'b0};
            2'd3: b_mult = b_triple;
            default: b_mult = '0;
        endcase
    end

    always_comb begin
        m_mult = '0;
        case (q)
            2'd0: m_mult = '0;
            2'd1: m_mult = m_wide;
            2'd2: m_mult = {2'b00, m_reg, 1'b0};
            2'd3: m_mult = m_triple;
            default: m_mult = '0;
        endcase
    end

    always_comb begin
        sum_b = acc + b_mult;
        sum_m = acc + m_mult;
        diff  = acc - m_wide;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            a_shift    <= '0;
            result_reg <= '0;
            acc        <= '0;
            b_triple   <= '0;
            m_triple   <= '0;
            digit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.in_a;
                        b_reg <= bus.in_b;
                        m_reg <= bus.in_m;
                    end
                end
                PRE: begin
                    b_triple  <= {3'b000, b_reg} + {2'b00, b_reg, 1'b0};
                    m_triple  <= m_wide + {2'b00, m_reg, 1'b0};
                    acc       <= '0;
                    digit_idx <= '0;
                    a_shift   <= a_reg;
                end
                ADDB: begin
                    acc <= sum_b;
                end
                ADDM: begin
                    acc       <= sum_m >> 2;
                    a_shift   <= a_shift >> 2;
                    digit_idx <= digit_idx + IW'(1);
                end
                SUB: begin
                    result_reg <= (acc >= m_wide) ? diff[N-1:0] : acc[N-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // The chosen q must always make the sum exactly divisible by 4.
    low_bits_zero: assert property (
        @(posedge clk) disable iff (reset)
        (state == ADDM) |-> (sum_m[1:0] == 2'b00)
    );

endmodule

// File: tb/tb_montgomery_radix4_param.sv
// Randomised self-checking bench for montgomery_radix4_param at N=8, 16 and 1024,
// compared against a plain modular-arithmetic reference model.
module tb_montgomery_radix4_param;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    montgomery_radix4_param_if #(.N(8))    bus8();
    montgomery_radix4_param_if #(.N(16))   bus16();
    montgomery_radix4_param_if #(.N(1024)) bus1k();

    montgomery_radix4_param #(.N(8))    dut8  (.clk(clk), .reset(reset), .bus(bus8));
    montgomery_radix4_param #(.N(16))   dut16 (.clk(clk), .reset(reset), .bus(bus16));
    montgomery_radix4_param #(.N(1024)) dut1k (.clk(clk), .reset(reset), .bus(bus1k));

    always #5 clk = ~clk;

    // A*B*2^-w mod M: reduce the full product, then halve modulo M w times.
    function automatic logic [1023:0] mont_model(input logic [1023:0] a, b, m, input int w);
        logic [2047:0] p;
        logic [1024:0] x;
        p = {1024'b0, a} * {1024'b0, b};
        p = p % {1024'b0, m};
        x = p[1024:0];
        for (int k = 0; k < w; k++) begin
            if (x[0]) x = x + {1'b0, m};
            x = x >> 1;
        end
        return x[1023:0];
    endfunction

    function automatic logic [1023:0] rand_wide(input int w);
        logic [1023:0] r;
        logic [1023:0] mask;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
        mask = {1024{1'b1}} >> (1024 - w);
        return r & mask;
    endfunction

    task automatic set_inputs(input int w, input logic [1023:0] a, b, m);
        case (w)
            8:  begin bus8.in_a = a[7:0];   bus8.in_b = b[7:0];   bus8.in_m = m[7:0];   end
            16: begin bus16.in_a = a[15:0]; bus16.in_b = b[15:0]; bus16.in_m = m[15:0]; end
            default: begin bus1k.in_a = a;  bus1k.in_b = b;       bus1k.in_m = m;       end
        endcase
    endtask

    task automatic set_start(input int w, input bit s);
        case (w)
            8:  bus8.start = s;
            16: bus16.start = s;
            default: bus1k.start = s;
        endcase
    endtask

    function automatic bit get_done(input int w);
        case (w)
            8:  return bus8.done;
            16: return bus16.done;
            default: return bus1k.done;
        endcase
    endfunction

    function automatic bit get_busy(input int w);
        case (w)
            8:  return bus8.busy;
            16: return bus16.busy;
            default: return bus1k.busy;
        endcase
    endfunction

    function automatic logic [1023:0] get_result(input int w);
        case (w)
            8:  return 1024'(bus8.result);
            16: return 1024'(bus16.result);
            default: return bus1k.result;
        endcase
    endfunction

    // One operation; inputs are scrambled right after the start edge, and an
    // optional extra start is raised lat edges in (inj_at). lat=-1 on timeout.
    task automatic run_op(input int w, input logic [1023:0] a, b, m, input int inj_at,
                          output logic [1023:0] res, output int lat, output bit clean_end);
        bit seen;
        seen      = 1'b0;
        res       = '0;
        clean_end = 1'b0;
        @(negedge clk);
        set_inputs(w, a, b, m);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        set_inputs(w, rand_wide(w), rand_wide(w), rand_wide(w) | 1024'd1);
        lat = 0;
        while (!seen && lat < w + 20) begin
            @(posedge clk);
            #1;
            lat++;
            set_start(w, lat == inj_at);
            if (get_done(w)) begin
                seen = 1'b1;
                res  = get_result(w);
            end
        end
        if (!seen) begin
            lat = -1;
        end else begin
            set_start(w, 1'b0);
            @(posedge clk);
            #1;
            clean_end = !get_done(w) && !get_busy(w);
        end
    endtask

    task automatic test_reset();
        int widths[3] = '{8, 16, 1024};
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_start(widths[k], 1'b0);
            set_inputs(widths[k], '0, '0, 1024'd3);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (get_busy(widths[k]) !== 1'b0) begin
                errors++; $display("FAIL reset_busy w=%0d got %0b expected 0", widths[k], get_busy(widths[k]));
            end
            if (get_done(widths[k]) !== 1'b0) begin
                errors++; $display("FAIL reset_done w=%0d got %0b expected 0", widths[k], get_done(widths[k]));
            end
            if (get_result(widths[k]) !== '0) begin
                errors++; $display("FAIL reset_result w=%0d got nonzero expected 0", widths[k]);
            end
        end
        set_start(8, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus8.busy !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored got busy=%0b expected 0", bus8.busy);
        end
        @(negedge clk);
        set_start(8, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got done=%0b busy=%0b expected 0 0", bus8.done, bus8.busy);
        end
    endtask

    task automatic test_directed();
        logic [1023:0] va[5] = '{1024'd5, 1024'd238, 1024'd1, 1024'd0, 1024'd77};
        logic [1023:0] vb[5] = '{1024'd7, 1024'd238, 1024'd1, 1024'd123, 1024'd0};
        logic [1023:0] ve[5] = '{1024'd227, 1024'd225, 1024'd225, 1024'd0, 1024'd0};
        logic [1023:0] res;
        int lat;
        bit clean;
        for (int k = 0; k < 5; k++) begin
            run_op(8, va[k], vb[k], 1024'd239, -1, res, lat, clean);
            checks += 3;
            if (res !== ve[k]) begin
                errors++; $display("FAIL directed_result[%0d] got %0d expected %0d", k, res[7:0], ve[k][7:0]);
            end
            if (lat !== 10) begin
                errors++; $display("FAIL directed_latency[%0d] got %0d expected 10", k, lat);
            end
            if (!clean) begin
                errors++; $display("FAIL directed_done_pulse[%0d] got done/busy still high expected both low", k);
            end
        end
        run_op(8, 1024'd5, 1024'd7, 1024'd239, -1, res, lat, clean);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus8.result !== 8'd227 || bus8.done !== 1'b0) begin
            errors++; $display("FAIL result_hold got result=%0d done=%0b expected 227 0", bus8.result, bus8.done);
        end
    endtask

    task automatic test_ignored_start();
        logic [1023:0] res;
        int lat;
        int extra;
        bit clean;
        run_op(8, 1024'd5, 1024'd7, 1024'd239, 3, res, lat, clean);
        checks += 3;
        if (res !== 1024'd227) begin
            errors++; $display("FAIL ignored_start_result got %0d expected 227", res[7:0]);
        end
        if (lat !== 10) begin
            errors++; $display("FAIL ignored_start_latency got %0d expected 10", lat);
        end
        if (!clean) begin
            errors++; $display("FAIL ignored_start_pulse got done/busy high expected both low");
        end
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus8.done || bus8.busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL ignored_start_queued got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int done_lat[$];
        logic [7:0] done_res[$];
        int lat;
        @(negedge clk);
        set_inputs(8, 1024'd5, 1024'd7, 1024'd239);
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        set_inputs(8, 1024'd238, 1024'd238, 1024'd239);
        for (lat = 1; lat <= 30; lat++) begin
            @(posedge clk);
            #1;
            if (bus8.done) begin
                done_lat.push_back(lat);
                done_res.push_back(bus8.result);
                if (done_lat.size() >= 2) bus8.start = 1'b0;
            end
        end
        bus8.start = 1'b0;
        checks++;
        if (done_lat.size() !== 2) begin
            errors++; $display("FAIL b2b_pulse_count got %0d expected 2", done_lat.size());
        end
        if (done_lat.size() >= 2) begin
            checks += 4;
            if (done_lat[0] !== 10) begin
                errors++; $display("FAIL b2b_first_latency got %0d expected 10", done_lat[0]);
            end
            if (done_res[0] !== 8'd227) begin
                errors++; $display("FAIL b2b_first_result got %0d expected 227", done_res[0]);
            end
            if (done_lat[1] !== 22) begin
                errors++; $display("FAIL b2b_second_latency got %0d expected 22", done_lat[1]);
            end
            if (done_res[1] !== 8'd225) begin
                errors++; $display("FAIL b2b_second_result got %0d expected 225", done_res[1]);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_mid_reset();
        logic [1023:0] res;
        logic [1023:0] expv;
        int lat;
        int stale;
        bit clean;
        @(negedge clk);
        set_inputs(8, 1024'd100, 1024'd200, 1024'd239);
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks += 3;
        if (bus8.busy !== 1'b0) begin
            errors++; $display("FAIL midreset_busy got %0b expected 0", bus8.busy);
        end
        if (bus8.done !== 1'b0) begin
            errors++; $display("FAIL midreset_done got %0b expected 0", bus8.done);
        end
        if (bus8.result !== 8'd0) begin
            errors++; $display("FAIL midreset_result got %0d expected 0", bus8.result);
        end
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus8.done || bus8.busy) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++; $display("FAIL midreset_stale got %0d active cycles expected 0", stale);
        end
        expv = mont_model(1024'd77, 1024'd150, 1024'd239, 8);
        run_op(8, 1024'd77, 1024'd150, 1024'd239, -1, res, lat, clean);
        checks += 2;
        if (res !== expv) begin
            errors++; $display("FAIL midreset_new_result got %0d expected %0d", res[7:0], expv[7:0]);
        end
        if (lat !== 10) begin
            errors++; $display("FAIL midreset_new_latency got %0d expected 10", lat);
        end
    endtask

    // mode 0: random odd M, mode 1: M = 2^w-1, mode 2: M = 3
    task automatic test_random(input int w, input int count, input int mode);
        logic [1023:0] a, b, m, res, expv;
        int lat;
        bit clean;
        for (int k = 0; k < count; k++) begin
            case (mode)
                1: m = {1024{1'b1}} >> (1024 - w);
                2: m = 1024'd3;
                default: begin
                    m = rand_wide(w) | 1024'd1;
                    if (m < 1024'd3) m = 1024'd3;
                end
            endcase
            a = rand_wide(w) % m;
            b = rand_wide(w) % m;
            if (k == 0) a = m - 1024'd1;
            expv = mont_model(a, b, m, w);
            run_op(w, a, b, m, -1, res, lat, clean);
            checks += 3;
            if (res !== expv) begin
                errors++;
                $display("FAIL random_result w=%0d mode=%0d #%0d got %0h expected %0h (low 256 bits)",
                         w, mode, k, res[255:0], expv[255:0]);
            end
            if (lat !== w + 2) begin
                errors++; $display("FAIL random_latency w=%0d #%0d got %0d expected %0d", w, k, lat, w + 2);
            end
            if (!clean) begin
                errors++; $display("FAIL random_done_pulse w=%0d #%0d got done/busy high expected both low", w, k);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got no completion expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_random(8, 10, 0);
        test_random(16, 10, 1);
        test_random(16, 10, 2);
        test_random(16, 10, 0);
        test_random(1024, 30, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
